sprite_fetch_sched: RTL and testbench

- Sequences the per-line refill of sprite graphics words from sprite RAM into the sprite manager's slot line buffers.
- Runs once per scanline, during HBLANK after sprite sorting completes.
- Walks the sorted slot list, skips inactive slots, and issues two word reads per active slot with read-latency-aware data-valid strobes.
- Replaces free-running pixel-column index decoding with a handshake-driven scheduler that detects line-deadline overruns.

---
 rtl/sprite_pkg.sv | 18 +
 rtl/sprite_slot_finder.sv | 26 ++
 rtl/sprite_fetch_sched.sv | 201 ++++++++++++++++++++
 tb/tb_sprite_fetch_sched.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite fetch path.
// Used by the sprite scheduler, slot finder and sorter.
package sprite_pkg;

  localparam int SPR_NUM_SLOTS = 16;
  localparam int SPR_IDX_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } fetch_state_e;

  localparam logic WORD_LO = 1'b0;
  localparam logic WORD_HI = 1'b1;

endpackage

// File: rtl/sprite_slot_finder.sv
// Lowest set mask bit at or above ptr_i.
// Purely combinational; shared with the sprite sorter.
module sprite_slot_finder
  import sprite_pkg::*;
#(
  parameter int N = SPR_NUM_SLOTS,
  parameter int W = SPR_IDX_W
) (
  input  logic [N-1:0] mask_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i] && (i >= int'(ptr_i))) begin
        found_o = 1'b1;
        idx_o   = W'(i);
      end
    end
  end

endmodule

// File: rtl/sprite_fetch_sched.sv
// HBLANK sprite line-buffer refill scheduler.
// Optional stats ports under SPRITE_FETCH_STATS_EN.
module sprite_fetch_sched
  import sprite_pkg::*;
#(
  parameter int NUM_SLOTS = SPR_NUM_SLOTS,
  parameter int IDX_W     = SPR_IDX_W,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_SLOTS-1:0] slot_active,
  output logic [IDX_W-1:0]     sprite_index,
  output logic                 sprite_word,
  output logic                 sprite_rd_en,
  output logic [1:0]           sprite_graphics_data_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
`ifdef SPRITE_FETCH_STATS_EN
  ,
  output logic [15:0]          overrun_count,
  output logic [7:0]           last_fetch_cycles
`endif
);

  fetch_state_e         state_q, state_d;
  logic [NUM_SLOTS-1:0] mask_q, mask_d;
  logic [NUM_SLOTS-1:0] fin_mask;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     fin_ptr, fin_idx;
  logic                 fin_found;
  logic                 word_q, word_d;
  logic [1:0]           lat_q, lat_d;
  logic                 rd_q, rd_d;
  logic [1:0]           dv_q, dv_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic                 last_strobe;

  // In IDLE the finder looks at the incoming occupancy directly,
  // otherwise at the latched mask with the current slot retired.
  always_comb begin
    if (state_q == IDLE) begin
      fin_mask = slot_active;
      fin_ptr  = '0;
    end else begin
      fin_mask = mask_q & ~(NUM_SLOTS'(1) << idx_q);
      fin_ptr  = idx_q;
    end
  end

  sprite_slot_finder #(
    .N (NUM_SLOTS),
    .W (IDX_W)
  ) u_finder (
    .mask_i  (fin_mask),
    .ptr_i   (fin_ptr),
    .found_o (fin_found),
    .idx_o   (fin_idx)
  );

  assign last_strobe = (state_q == WAIT)
                    && (lat_q == 2'd1)
                    && (word_q == WORD_HI)
                    && !fin_found;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    word_d  = word_q;
    lat_d   = lat_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mask_d = slot_active;
          if (fin_found) begin
            state_d = ISSUE;
            idx_d   = fin_idx;
            word_d  = WORD_LO;
          end else begin
            state_d = FIN;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
          ovr_d   = 1'b1;
        end else begin
          state_d = WAIT;
          lat_d   = 2'(RD_LAT);
        end
      end
      WAIT: begin
        if (abort && !last_strobe) begin
          state_d = IDLE;
          ovr_d   = 1'b1;
        end else if (lat_q == 2'd1) begin
          if (word_q == WORD_LO) begin
            state_d = ISSUE;
            word_d  = WORD_HI;
          end else begin
            mask_d = fin_mask;
            if (fin_found) begin
              state_d = ISSUE;
              idx_d   = fin_idx;
              word_d  = WORD_LO;
            end else begin
              state_d = FIN;
              done_d  = 1'b1;
            end
          end
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      FIN: begin
        // Empty refills reach FIN without done; pulse it on exit.
        state_d = IDLE;
        done_d  = !done_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_d   = (state_d == ISSUE);
  assign busy_d = (state_d != IDLE);
  assign dv_d   = ((state_d == WAIT) && (lat_d == 2'd1))
                ? (word_d ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      word_q  <= WORD_LO;
      lat_q   <= '0;
      rd_q    <= 1'b0;
      dv_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      lat_q   <= lat_d;
      rd_q    <= rd_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sprite_index               = idx_q;
  assign sprite_word                = word_q;
  assign sprite_rd_en               = rd_q;
  assign sprite_graphics_data_valid = dv_q;
  assign busy                       = busy_q;
  assign done                       = done_q;
  assign overrun                    = ovr_q;

`ifdef SPRITE_FETCH_STATS_EN
  logic [15:0] ocnt_q;
  logic [7:0]  cyc_q;
  logic [7:0]  last_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ocnt_q <= '0;
      cyc_q  <= '0;
      last_q <= '0;
    end else begin
      if (ovr_d && (ocnt_q != 16'hFFFF)) begin
        ocnt_q <= ocnt_q + 16'd1;
      end
      if (state_q == IDLE) begin
        cyc_q <= '0;
      end else if (cyc_q != 8'hFF) begin
        cyc_q <= cyc_q + 8'd1;
      end
      if (state_q == FIN) begin
        last_q <= (cyc_q == 8'hFF) ? 8'hFF : cyc_q + 8'd1;
      end
    end
  end

  assign overrun_count     = ocnt_q;
  assign last_fetch_cycles = last_q;
`endif

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Directed bench for sprite_fetch_sched at RD_LAT=1 and RD_LAT=3.
// Stats checks compile in with SPRITE_FETCH_STATS_EN.
module tb_sprite_fetch_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [15:0] slot_active;

  logic [3:0]  idx1, idx3;
  logic        word1, word3;
  logic        rd1, rd3;
  logic [1:0]  dv1, dv3;
  logic        busy1, busy3;
  logic        done1, done3;
  logic        ovr1, ovr3;
`ifdef SPRITE_FETCH_STATS_EN
  logic [15:0] oc1, oc3;
  logic [7:0]  lf1, lf3;
`endif

  typedef struct packed {
    logic       rd;
    logic [1:0] dv;
    logic [3:0] idx;
    logic       word;
    logic       busy;
    logic       done;
    logic       ovr;
  } smp_t;

  smp_t s1 [0:127];
  smp_t s3 [0:127];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sprite_fetch_sched #(
    .NUM_SLOTS (16),
    .IDX_W     (4),
    .RD_LAT    (1)
  ) u_dut1 (
    .clk                        (clk),
    .resetn                     (resetn),
    .start                      (start),
    .abort                      (abort),
    .slot_active                (slot_active),
    .sprite_index               (idx1),
    .sprite_word                (word1),
    .sprite_rd_en               (rd1),
    .sprite_graphics_data_valid (dv1),
    .busy                       (busy1),
    .done                       (done1),
    .overrun                    (ovr1)
`ifdef SPRITE_FETCH_STATS_EN
    ,
    .overrun_count              (oc1),
    .last_fetch_cycles          (lf1)
`endif
  );

  sprite_fetch_sched #(
    .NUM_SLOTS (16),
    .IDX_W     (4),
    .RD_LAT    (3)
  ) u_dut3 (
    .clk                        (clk),
    .resetn                     (resetn),
    .start                      (start),
    .abort                      (abort),
    .slot_active                (slot_active),
    .sprite_index               (idx3),
    .sprite_word                (word3),
    .sprite_rd_en               (rd3),
    .sprite_graphics_data_valid (dv3),
    .busy                       (busy3),
    .done                       (done3),
    .overrun                    (ovr3)
`ifdef SPRITE_FETCH_STATS_EN
    ,
    .overrun_count              (oc3),
    .last_fetch_cycles          (lf3)
`endif
  );

  task automatic record(input int c);
    s1[c] = '{rd1, dv1, idx1, word1, busy1, done1, ovr1};
    s3[c] = '{rd3, dv3, idx3, word3, busy3, done3, ovr3};
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #3;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the start cycle; s*[c] holds outputs seen in cycle c.
  task automatic run(input logic [15:0] act, input logic ab0,
                     input int ab_cyc, input int s2_cyc,
                     input logic [15:0] act2, input int ncyc);
    start       = 1'b1;
    abort       = ab0;
    slot_active = act;
    record(0);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      record(c);
      start       = (c == s2_cyc);
      abort       = (c == ab_cyc);
      slot_active = (c == s2_cyc) ? act2 : act;
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] got1, got3;
    resetn      = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    slot_active = '0;
    #2;
    got1 = s1[0];
    got1 = {rd1, dv1, idx1, word1, busy1, done1};
    got3 = {rd3, dv3, idx3, word3, busy3, done3};
    n_cmp++;
    if ({got1, ovr1} !== 11'd0) begin
      $display("FAIL reset_lat1: got %h want 0", {got1, ovr1});
      n_bad++;
    end
    n_cmp++;
    if ({got3, ovr3} !== 11'd0) begin
      $display("FAIL reset_lat3: got %h want 0", {got3, ovr3});
      n_bad++;
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy1, busy3, done1, ovr1} !== 4'd0) begin
      $display("FAIL reset_idle: got %b want 0000",
               {busy1, busy3, done1, ovr1});
      n_bad++;
    end
  endtask

  task automatic test_two_slots();
    logic [5:0] got, exp;
    logic [4:0] gix, eix;
    do_reset();
    run(16'h0005, 1'b0, -1, -1, 16'h0, 12);
    for (int c = 0; c <= 12; c++) begin
      exp[5]   = (c == 1 || c == 3 || c == 5 || c == 7);
      exp[4:3] = (c == 2 || c == 6) ? 2'b01 :
                 (c == 4 || c == 8) ? 2'b10 : 2'b00;
      exp[2]   = (c >= 1 && c <= 9);
      exp[1]   = (c == 9);
      exp[0]   = 1'b0;
      got = {s1[c].rd, s1[c].dv, s1[c].busy, s1[c].done, s1[c].ovr};
      n_cmp++;
      if (got !== exp) begin
        $display("FAIL two_slots_ctl c%0d: got %b want %b", c, got, exp);
        n_bad++;
      end
    end
    for (int c = 1; c <= 12; c++) begin
      eix[4:1] = (c <= 4) ? 4'd0 : 4'd2;
      eix[0]   = (c >= 9) ? 1'b1 : 1'(((c - 1) / 2) % 2);
      gix = {s1[c].idx, s1[c].word};
      n_cmp++;
      if (gix !== eix) begin
        $display("FAIL two_slots_idx c%0d: got %h want %h", c, gix, eix);
        n_bad++;
      end
    end
  endtask

  task automatic test_empty();
    logic [5:0] got, exp;
    do_reset();
    run(16'h0000, 1'b0, -1, -1, 16'h0, 6);
    for (int c = 0; c <= 6; c++) begin
      exp = {1'b0, 2'b00, 1'(c == 1), 1'(c == 2), 1'b0};
      got = {s1[c].rd, s1[c].dv, s1[c].busy, s1[c].done, s1[c].ovr};
      n_cmp++;
      if (got !== exp) begin
        $display("FAIL empty c%0d: got %b want %b", c, got, exp);
        n_bad++;
      end
    end
  endtask

  task automatic test_full();
    int         nrd;
    logic [4:0] gix, eix;
    nrd = 0;
    do_reset();
    run(16'hFFFF, 1'b0, -1, -1, 16'h0, 70);
    for (int c = 0; c <= 70; c++) begin
      if (s1[c].rd) begin
        eix = {4'(nrd / 2), 1'(nrd % 2)};
        gix = {s1[c].idx, s1[c].word};
        n_cmp++;
        if (gix !== eix || c != 2 * nrd + 1) begin
          $display("FAIL full_rd c%0d: got %h want %h at c%0d",
                   c, gix, eix, 2 * nrd + 1);
          n_bad++;
        end
        nrd++;
      end
      n_cmp++;
      if (s1[c].done !== (c == 65)) begin
        $display("FAIL full_done c%0d: got %b want %b",
                 c, s1[c].done, (c == 65));
        n_bad++;
      end
    end
    n_cmp++;
    if (nrd != 32) begin
      $display("FAIL full_rd_count: got %0d want 32", nrd);
      n_bad++;
    end
    n_cmp++;
    if ({s1[65].busy, s1[66].busy} !== 2'b10) begin
      $display("FAIL full_busy_end: got %b want 10",
               {s1[65].busy, s1[66].busy});
      n_bad++;
    end
  endtask

  task automatic test_full_abort();
    do_reset();
    run(16'hFFFF, 1'b0, 40, -1, 16'h0, 50);
    n_cmp++;
    if (s1[40].dv !== 2'b10) begin
      $display("FAIL abort_last_strobe: got %b want 10", s1[40].dv);
      n_bad++;
    end
    for (int c = 0; c <= 50; c++) begin
      n_cmp++;
      if (s1[c].ovr !== (c == 41) || s1[c].done !== 1'b0) begin
        $display("FAIL abort_ovr c%0d: got ovr %b done %b want %b 0",
                 c, s1[c].ovr, s1[c].done, (c == 41));
        n_bad++;
      end
      if (c > 40) begin
        n_cmp++;
        if ({s1[c].rd, s1[c].dv, s1[c].busy} !== 4'd0) begin
          $display("FAIL abort_quiet c%0d: got %b want 0000",
                   c, {s1[c].rd, s1[c].dv, s1[c].busy});
          n_bad++;
        end
      end
    end
  endtask

  task automatic test_start_abort();
    do_reset();
    run(16'h0005, 1'b1, -1, -1, 16'h0, 6);
    for (int c = 0; c <= 6; c++) begin
      n_cmp++;
      if ({s1[c].rd, s1[c].busy, s1[c].done, s1[c].ovr} !== 4'd0) begin
        $display("FAIL start_abort c%0d: got %b want 0000", c,
                 {s1[c].rd, s1[c].busy, s1[c].done, s1[c].ovr});
        n_bad++;
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [4:0] gix, eix;
    logic       erd;
    do_reset();
    run(16'h0005, 1'b0, -1, 3, 16'hFFFF, 14);
    for (int c = 1; c <= 14; c++) begin
      erd = (c == 1 || c == 3 || c == 5 || c == 7);
      n_cmp++;
      if (s1[c].rd !== erd || s1[c].done !== (c == 9)) begin
        $display("FAIL busy_start c%0d: got rd %b done %b want %b %b",
                 c, s1[c].rd, s1[c].done, erd, (c == 9));
        n_bad++;
      end
      if (erd) begin
        eix = {((c <= 3) ? 4'd0 : 4'd2), 1'(c == 3 || c == 7)};
        gix = {s1[c].idx, s1[c].word};
        n_cmp++;
        if (gix !== eix) begin
          $display("FAIL busy_start_idx c%0d: got %h want %h",
                   c, gix, eix);
          n_bad++;
        end
      end
    end
  endtask

  task automatic test_lat3();
    logic [5:0] got, exp;
    do_reset();
    run(16'h8000, 1'b0, 8, -1, 16'h0, 12);
    for (int c = 0; c <= 12; c++) begin
      exp[5]   = (c == 1 || c == 5);
      exp[4:3] = (c == 4) ? 2'b01 : (c == 8) ? 2'b10 : 2'b00;
      exp[2]   = (c >= 1 && c <= 9);
      exp[1]   = (c == 9);
      exp[0]   = 1'b0;
      got = {s3[c].rd, s3[c].dv, s3[c].busy, s3[c].done, s3[c].ovr};
      n_cmp++;
      if (got !== exp) begin
        $display("FAIL lat3 c%0d: got %b want %b", c, got, exp);
        n_bad++;
      end
    end
    n_cmp++;
    if ({s3[1].idx, s3[1].word, s3[5].idx, s3[5].word} !== 10'h3DF) begin
      $display("FAIL lat3_idx: got %h want 3df",
               {s3[1].idx, s3[1].word, s3[5].idx, s3[5].word});
      n_bad++;
    end
  endtask

  task automatic test_issue_abort();
    do_reset();
    run(16'h8000, 1'b0, 1, -1, 16'h0, 10);
    for (int c = 0; c <= 10; c++) begin
      n_cmp++;
      if ({s1[c].ovr, s3[c].ovr} !== {2{1'(c == 2)}}
          || {s1[c].dv, s3[c].dv, s1[c].done, s3[c].done} !== 6'd0) begin
        $display("FAIL issue_abort c%0d: got ovr %b%b dv %b%b want %b",
                 c, s1[c].ovr, s3[c].ovr, s1[c].dv, s3[c].dv, (c == 2));
        n_bad++;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run(16'hFFFF, 1'b0, -1, -1, 16'h0, 6);
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({rd1, dv1, idx1, word1, busy1, busy3, idx3} !== 14'd0) begin
      $display("FAIL reset_mid: got %h want 0",
               {rd1, dv1, idx1, word1, busy1, busy3, idx3});
      n_bad++;
    end
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifdef SPRITE_FETCH_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run(16'hFFFF, 1'b0, 3, -1, 16'h0, 6);
    end
    n_cmp++;
    if (oc1 !== 16'd3 || oc3 !== 16'd3) begin
      $display("FAIL stats_ovr: got %0d %0d want 3 3", oc1, oc3);
      n_bad++;
    end
    run(16'h0001, 1'b0, -1, -1, 16'h0, 12);
    n_cmp++;
    if (lf1 !== 8'd5 || lf3 !== 8'd9) begin
      $display("FAIL stats_cycles: got %0d %0d want 5 9", lf1, lf3);
      n_bad++;
    end
    n_cmp++;
    if (oc1 !== 16'd3) begin
      $display("FAIL stats_ovr_hold: got %0d want 3", oc1);
      n_bad++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_slots();
    test_empty();
    test_full();
    test_full_abort();
    test_start_abort();
    test_start_while_busy();
    test_lat3();
    test_issue_abort();
    test_reset_mid();
`ifdef SPRITE_FETCH_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
